// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - Shared opcode, FSM state and in-flight entry types for branch resolution
package bp_pkg;

  localparam logic [6:0] BRANCH_OP = 7'b1100011;
  localparam int         ENTRY_XLEN = 32;

  localparam logic [0:0] ST_TRACK   = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic                  taken;
    logic [ENTRY_XLEN-1:0] target;
  } entry_t;

  function automatic logic is_branch(input logic [6:0] opcode);
    return opcode == BRANCH_OP;
  endfunction

endpackage

// File: rtl/branch_resolution_ctrl_if.sv
// rtl/branch_resolution_ctrl_if.sv - Fetch/predictor/EX bundle seen by the branch resolution controller
interface branch_resolution_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            fetch_valid;
  logic [31:0]     fetch_instr;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            resolve_valid;
  logic            resolve_taken;
  logic [XLEN-1:0] resolve_target;

  logic            stall_fetch;
  logic            upd_valid;
  logic            upd_truth;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   inflight_cnt;
  logic [15:0]     mispredict_cnt;
  logic            protocol_err;

  modport master (
    output fetch_valid, fetch_instr, fetch_pc, pred_taken, pred_target,
           resolve_valid, resolve_taken, resolve_target,
    input  stall_fetch, upd_valid, upd_truth, flush, redirect_pc,
           inflight_cnt, mispredict_cnt, protocol_err
  );

  modport slave (
    input  fetch_valid, fetch_instr, fetch_pc, pred_taken, pred_target,
           resolve_valid, resolve_taken, resolve_target,
    output stall_fetch, upd_valid, upd_truth, flush, redirect_pc,
           inflight_cnt, mispredict_cnt, protocol_err
  );
endinterface

// File: rtl/branch_queue.sv
// rtl/branch_queue.sv - In-order circular FIFO of in-flight branch entries
module branch_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  entry_t                     wr_data_i,
  output entry_t                     head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  // Storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/branch_resolution_ctrl.sv
// rtl/branch_resolution_ctrl.sv - Tracks predicted branches, checks EX resolution, trains predictor and redirects
module branch_resolution_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  branch_resolution_ctrl_if.slave bus_io
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [0:0]      state_q;
  logic [0:0]      state_d;
  entry_t          head;
  entry_t          wr_entry;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  logic            in_track;
  logic            do_resolve;
  logic            mispredict;
  logic            push;
  logic            pop;
  logic            upd_valid_q;
  logic            upd_truth_q;
  logic            flush_q;
  logic            perr_q;
  logic [XLEN-1:0] redirect_q;
  logic [XLEN-1:0] redirect_d;
  logic [15:0]     mp_cnt_q;
  logic            unused_instr_bits;

  assign unused_instr_bits = ^bus_io.fetch_instr[31:7];

  assign in_track   = (state_q == ST_TRACK);
  assign do_resolve = in_track & bus_io.resolve_valid & ~q_empty;
  assign mispredict = do_resolve &
                      ((bus_io.resolve_taken != head.taken) |
                       (bus_io.resolve_taken & (bus_io.resolve_target != head.target)));

  // Full blocks the push even when this cycle's pop would free a slot.
  assign push = in_track & bus_io.fetch_valid & is_branch(bus_io.fetch_instr[6:0]) &
                ~q_full & ~mispredict;
  assign pop  = do_resolve & ~mispredict;

  assign wr_entry   = '{pc: bus_io.fetch_pc, taken: bus_io.pred_taken, target: bus_io.pred_target};
  assign redirect_d = bus_io.resolve_taken ? bus_io.resolve_target : head.pc + XLEN'(4);
  assign state_d    = mispredict ? ST_RECOVER : ST_TRACK;

  branch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .pop_i     (pop),
    .clear_i   (mispredict),
    .wr_data_i (wr_entry),
    .head_o    (head),
    .full_o    (q_full),
    .empty_o   (q_empty),
    .count_o   (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_TRACK;
      upd_valid_q <= 1'b0;
      upd_truth_q <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      mp_cnt_q    <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      upd_valid_q <= do_resolve;
      upd_truth_q <= do_resolve & bus_io.resolve_taken;
      flush_q     <= mispredict;
      redirect_q  <= mispredict ? redirect_d : '0;
      if (mispredict && (mp_cnt_q != 16'hFFFF)) mp_cnt_q <= mp_cnt_q + 16'd1;
      if (in_track && bus_io.resolve_valid && q_empty) perr_q <= 1'b1;
    end
  end

  assign bus_io.stall_fetch    = q_full;
  assign bus_io.inflight_cnt   = q_count;
  assign bus_io.upd_valid      = upd_valid_q;
  assign bus_io.upd_truth      = upd_truth_q;
  assign bus_io.flush          = flush_q;
  assign bus_io.redirect_pc    = redirect_q;
  assign bus_io.mispredict_cnt = mp_cnt_q;
  assign bus_io.protocol_err   = perr_q;

endmodule

// File: tb/tb_branch_resolution_ctrl.sv
// tb/tb_branch_resolution_ctrl.sv - Self-checking bench with directed scenarios and a queue-based reference model
module tb_branch_resolution_ctrl;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] BR_INSTR = 32'h0000_0063;
  localparam logic [31:0] ALU_INSTR = 32'h0000_0033;

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] target;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolution_ctrl_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  branch_resolution_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  ent_t        m_q[$];
  bit          m_recover;
  int          m_mp;
  bit          m_perr;
  bit          e_upd_valid;
  bit          e_upd_truth;
  bit          e_flush;
  logic [31:0] e_redirect;
  int          checks = 0;
  int          errors = 0;

  // One clock of stimulus; the model applies the behavioural rules to predict post-edge outputs.
  task automatic cycle(input bit rst, input bit fv, input logic [31:0] instr, input logic [31:0] pc,
                       input bit pt, input logic [31:0] ptgt, input bit rv, input bit rt,
                       input logic [31:0] rtgt);
    ent_t h;
    bit   resolving;
    bit   mp;
    bit   enq;
    reset              = rst;
    bus.fetch_valid    = fv;
    bus.fetch_instr    = instr;
    bus.fetch_pc       = pc;
    bus.pred_taken     = pt;
    bus.pred_target    = ptgt;
    bus.resolve_valid  = rv;
    bus.resolve_taken  = rt;
    bus.resolve_target = rtgt;
    mp        = 1'b0;
    resolving = !m_recover && rv && (m_q.size() > 0);
    enq       = !m_recover && fv && (instr[6:0] == 7'b1100011) && (m_q.size() < DEPTH);
    e_upd_valid = resolving;
    e_upd_truth = rt;
    e_flush     = 1'b0;
    if (!m_recover && rv && m_q.size() == 0) m_perr = 1'b1;
    if (resolving) begin
      h  = m_q[0];
      mp = (rt != h.taken) || (rt && (rtgt != h.target));
    end
    if (rst) begin
      m_q.delete();
      m_mp        = 0;
      m_perr      = 1'b0;
      e_upd_valid = 1'b0;
      mp          = 1'b0;
    end else if (mp) begin
      m_q.delete();
      e_flush    = 1'b1;
      e_redirect = rt ? rtgt : h.pc + 32'd4;
      if (m_mp < 65535) m_mp++;
    end else begin
      if (resolving) void'(m_q.pop_front());
      if (enq) m_q.push_back('{pc: pc, taken: pt, target: ptgt});
    end
    m_recover = mp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic fetch_br(input logic [31:0] pc, input bit pt, input logic [31:0] tgt);
    cycle(0, 1, BR_INSTR, pc, pt, tgt, 0, 0, 32'h0);
  endtask

  task automatic resolve(input bit rt, input logic [31:0] tgt);
    cycle(0, 0, 32'h0, 32'h0, 0, 32'h0, 1, rt, tgt);
  endtask

  task automatic do_reset();
    cycle(1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    cycle(1, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.stall_fetch, bus.upd_valid, bus.upd_truth, bus.flush, bus.protocol_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000",
        {bus.stall_fetch, bus.upd_valid, bus.upd_truth, bus.flush, bus.protocol_err});
    end
    checks++;
    if (bus.redirect_pc !== 32'h0 || bus.mispredict_cnt !== 16'h0 || bus.inflight_cnt !== '0) begin
      errors++; $display("FAIL reset_values: redirect %h cnt %0d inflight %0d required 0",
        bus.redirect_pc, bus.mispredict_cnt, bus.inflight_cnt);
    end
  endtask

  task automatic test_correct_predict();
    fetch_br(32'h100, 1, 32'h200);
    checks++;
    if (bus.inflight_cnt !== CW'(1)) begin
      errors++; $display("FAIL correct_enq: inflight %0d required 1", bus.inflight_cnt);
    end
    resolve(1, 32'h200);
    checks++;
    if (bus.upd_valid !== 1'b1 || bus.upd_truth !== 1'b1 || bus.flush !== 1'b0 ||
        bus.inflight_cnt !== CW'(0)) begin
      errors++; $display("FAIL correct_resolve: upd %b truth %b flush %b inflight %0d required 1 1 0 0",
        bus.upd_valid, bus.upd_truth, bus.flush, bus.inflight_cnt);
    end
    idle();
    checks++;
    if (bus.upd_valid !== 1'b0) begin
      errors++; $display("FAIL correct_strobe_width: upd %b required 0", bus.upd_valid);
    end
  endtask

  task automatic test_mispredict_direction();
    fetch_br(32'h100, 1, 32'h200);
    resolve(0, 32'h0);
    checks++;
    if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h104 || bus.mispredict_cnt !== 16'd1 ||
        bus.upd_valid !== 1'b1 || bus.upd_truth !== 1'b0) begin
      errors++; $display("FAIL mp_dir: flush %b redirect %h cnt %0d upd %b truth %b required 1 104 1 1 0",
        bus.flush, bus.redirect_pc, bus.mispredict_cnt, bus.upd_valid, bus.upd_truth);
    end
    idle();
    checks++;
    if (bus.flush !== 1'b0) begin
      errors++; $display("FAIL mp_dir_flush_pulse: flush %b required 0", bus.flush);
    end
  endtask

  task automatic test_mispredict_target();
    fetch_br(32'h100, 1, 32'h200);
    resolve(1, 32'h300);
    checks++;
    if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h300 || bus.mispredict_cnt !== 16'd2) begin
      errors++; $display("FAIL mp_target: flush %b redirect %h cnt %0d required 1 300 2",
        bus.flush, bus.redirect_pc, bus.mispredict_cnt);
    end
    idle();
  endtask

  task automatic test_full_queue();
    do_reset();
    for (int i = 0; i < DEPTH; i++) fetch_br(32'h10 * (i + 1), 0, 32'h0);
    checks++;
    if (bus.stall_fetch !== 1'b1 || bus.inflight_cnt !== CW'(DEPTH)) begin
      errors++; $display("FAIL full_stall: stall %b inflight %0d required 1 %0d",
        bus.stall_fetch, bus.inflight_cnt, DEPTH);
    end
    cycle(0, 1, BR_INSTR, 32'h50, 0, 32'h0, 1, 0, 32'h0);
    checks++;
    if (bus.inflight_cnt !== CW'(3) || bus.stall_fetch !== 1'b0) begin
      errors++; $display("FAIL full_blocks_enq: inflight %0d stall %b required 3 0",
        bus.inflight_cnt, bus.stall_fetch);
    end
    resolve(0, 32'h0);
    cycle(0, 1, BR_INSTR, 32'h60, 0, 32'h0, 1, 0, 32'h0);
    checks++;
    if (bus.inflight_cnt !== CW'(2) || bus.flush !== 1'b0) begin
      errors++; $display("FAIL enq_and_pop: inflight %0d flush %b required 2 0",
        bus.inflight_cnt, bus.flush);
    end
    cycle(0, 1, ALU_INSTR, 32'h70, 0, 32'h0, 0, 0, 32'h0);
    checks++;
    if (bus.inflight_cnt !== CW'(2)) begin
      errors++; $display("FAIL non_branch_ignored: inflight %0d required 2", bus.inflight_cnt);
    end
  endtask

  task automatic test_mispredict_with_fetch();
    do_reset();
    for (int i = 0; i < 3; i++) fetch_br(32'h400 + 4 * i, 0, 32'h0);
    cycle(0, 1, BR_INSTR, 32'h500, 0, 32'h0, 1, 1, 32'h800);
    checks++;
    if (bus.inflight_cnt !== CW'(0) || bus.flush !== 1'b1 || bus.redirect_pc !== 32'h800) begin
      errors++; $display("FAIL mp_clear: inflight %0d flush %b redirect %h required 0 1 800",
        bus.inflight_cnt, bus.flush, bus.redirect_pc);
    end
    cycle(0, 1, BR_INSTR, 32'h600, 0, 32'h0, 1, 0, 32'h0);
    checks++;
    if (bus.inflight_cnt !== CW'(0) || bus.upd_valid !== 1'b0 || bus.protocol_err !== 1'b0) begin
      errors++; $display("FAIL recover_ignores: inflight %0d upd %b perr %b required 0 0 0",
        bus.inflight_cnt, bus.upd_valid, bus.protocol_err);
    end
    fetch_br(32'h700, 0, 32'h0);
    checks++;
    if (bus.inflight_cnt !== CW'(1)) begin
      errors++; $display("FAIL back_to_track: inflight %0d required 1", bus.inflight_cnt);
    end
  endtask

  task automatic test_protocol_err_and_reset();
    do_reset();
    resolve(1, 32'h0);
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.upd_valid !== 1'b0) begin
      errors++; $display("FAIL perr_set: perr %b upd %b required 1 0", bus.protocol_err, bus.upd_valid);
    end
    idle(); idle();
    checks++;
    if (bus.protocol_err !== 1'b1) begin
      errors++; $display("FAIL perr_sticky: perr %b required 1", bus.protocol_err);
    end
    fetch_br(32'h100, 1, 32'h200);
    resolve(0, 32'h0);
    cycle(1, 1, BR_INSTR, 32'h900, 0, 32'h0, 0, 0, 32'h0);
    reset = 1'b0;
    checks++;
    if (bus.flush !== 1'b0 || bus.inflight_cnt !== CW'(0) || bus.mispredict_cnt !== 16'd0 ||
        bus.protocol_err !== 1'b0 || bus.redirect_pc !== 32'h0) begin
      errors++; $display("FAIL reset_in_recover: flush %b inflight %0d cnt %0d perr %b redirect %h required all 0",
        bus.flush, bus.inflight_cnt, bus.mispredict_cnt, bus.protocol_err, bus.redirect_pc);
    end
    fetch_br(32'h100, 1, 32'h200);
    cycle(1, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
    reset = 1'b0;
    checks++;
    if (bus.flush !== 1'b0 || bus.mispredict_cnt !== 16'd0 || bus.upd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_drops_flush: flush %b cnt %0d upd %b required 0 0 0",
        bus.flush, bus.mispredict_cnt, bus.upd_valid);
    end
    fetch_br(32'h104, 0, 32'h0);
    checks++;
    if (bus.inflight_cnt !== CW'(1)) begin
      errors++; $display("FAIL track_after_reset: inflight %0d required 1", bus.inflight_cnt);
    end
  endtask

  task automatic test_random();
    ent_t        h;
    bit          rst, fv, pt, rv, rt;
    logic [31:0] instr, pc, ptgt, rtgt;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      fv    = ($urandom_range(0, 3) != 0);
      instr = ($urandom_range(0, 4) != 0) ? BR_INSTR | ($urandom & 32'hFFFF_FF80) : $urandom;
      pc    = $urandom & 32'hFFFF_FFFC;
      pt    = $urandom_range(0, 1);
      ptgt  = $urandom & 32'hFFFF_FFFC;
      rv    = ($urandom_range(0, 2) == 0);
      rt    = $urandom_range(0, 1);
      rtgt  = $urandom & 32'hFFFF_FFFC;
      if (m_q.size() > 0) begin
        h    = m_q[0];
        rt   = ($urandom_range(0, 9) < 7) ? h.taken : !h.taken;
        rtgt = ($urandom_range(0, 9) < 8) ? h.target : rtgt;
      end else if ($urandom_range(0, 9) != 0) begin
        rv = 1'b0;
      end
      cycle(rst, fv, instr, pc, pt, ptgt, rv, rt, rtgt);
      checks++;
      if (bus.inflight_cnt !== CW'(m_q.size()) || bus.stall_fetch !== (m_q.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_occupancy @%0d: inflight %0d stall %b required %0d %b",
          n, bus.inflight_cnt, bus.stall_fetch, m_q.size(), m_q.size() == DEPTH);
      end
      checks++;
      if (bus.upd_valid !== e_upd_valid || (e_upd_valid && bus.upd_truth !== e_upd_truth)) begin
        errors++; $display("FAIL rnd_update @%0d: upd %b truth %b required %b %b",
          n, bus.upd_valid, bus.upd_truth, e_upd_valid, e_upd_truth);
      end
      checks++;
      if (bus.flush !== e_flush || (e_flush && bus.redirect_pc !== e_redirect)) begin
        errors++; $display("FAIL rnd_flush @%0d: flush %b redirect %h required %b %h",
          n, bus.flush, bus.redirect_pc, e_flush, e_redirect);
      end
      checks++;
      if (bus.mispredict_cnt !== 16'(m_mp) || bus.protocol_err !== m_perr) begin
        errors++; $display("FAIL rnd_counters @%0d: cnt %0d perr %b required %0d %b",
          n, bus.mispredict_cnt, bus.protocol_err, m_mp, m_perr);
      end
    end
  endtask

  initial begin
    m_recover = 1'b0;
    m_mp      = 0;
    m_perr    = 1'b0;
    test_reset();
    test_correct_predict();
    test_mispredict_direction();
    test_mispredict_target();
    test_full_queue();
    test_mispredict_with_fetch();
    test_protocol_err_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
